// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer for the 16-bit-word flash program store.
// Owns the program counter, drives the flash read address and hands fetched
// instruction words to the decoder through a valid/ready slot.
// Optional feature macro: FC_LONG_INST_EN enables two-word AVR instructions
// (LDS/STS/JMP/CALL), which are assembled into one slot via the FETCH2 state.
// With the macro undefined every word is single-word; inst_long/inst_ext stay 0.
module fetch_ctrl #(
    parameter int unsigned size_inst = 16,
    parameter int unsigned size_fm   = 8,
    parameter int unsigned RST_VEC   = 0
) (
    input  logic                 clk_fc,
    input  logic                 rst_fc,
    input  logic                 en_fc,
    output logic [size_fm-1:0]   fm_addr,
    output logic                 fm_en,
    input  logic [size_inst-1:0] fm_data,
    input  logic                 br_req,
    input  logic [size_fm-1:0]   br_target,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    output logic [size_inst-1:0] inst_word,
    output logic [size_inst-1:0] inst_ext,
    output logic                 inst_long,
    output logic [size_fm-1:0]   inst_pc
);

    localparam logic [size_fm-1:0] RST_PC = RST_VEC[size_fm-1:0];
    localparam logic [size_fm-1:0] PC_ONE = {{(size_fm-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        FETCH  = 2'd1,
        FETCH2 = 2'd2
    } state_t;

    state_t               state_reg, state_next;
    logic [size_fm-1:0]   pc_reg, pc_next;
    logic                 valid_reg, valid_next;
    logic                 long_reg, long_next;
    logic [size_inst-1:0] word_reg, word_next;
    logic [size_inst-1:0] ext_reg, ext_next;
    logic [size_fm-1:0]   ipc_reg, ipc_next;

    logic free;
    logic is_long;

    // The slot can take a new word when empty or when it is being consumed now.
    assign free = !valid_reg || inst_ready;

`ifdef FC_LONG_INST_EN
    // LDS/STS and JMP/CALL carry a second word (address/immediate).
    assign is_long = ((fm_data & 16'hFC0F) == 16'h9000) ||
                     ((fm_data & 16'hFE0C) == 16'h940C);
`else
    assign is_long = 1'b0;
`endif

    assign fm_addr    = pc_reg;
    // The flash must be enabled during BOOT so it loads its image.
    assign fm_en      = (state_reg == BOOT) ? 1'b1 : en_fc;
    assign inst_valid = valid_reg;
    assign inst_long  = long_reg;
    assign inst_word  = word_reg;
    assign inst_ext   = ext_reg;
    assign inst_pc    = ipc_reg;

    // State register and slot registers; asynchronous reset clears everything.
    always_ff @(posedge clk_fc or posedge rst_fc) begin
        if (rst_fc) begin
            state_reg <= BOOT;
            pc_reg    <= RST_PC;
            valid_reg <= 1'b0;
            long_reg  <= 1'b0;
            word_reg  <= '0;
            ext_reg   <= '0;
            ipc_reg   <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            valid_reg <= valid_next;
            long_reg  <= long_next;
            word_reg  <= word_next;
            ext_reg   <= ext_next;
            ipc_reg   <= ipc_next;
        end
    end

    // Next-state logic: enable freezes all, branch wins, else walk the FSM.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        valid_next = valid_reg;
        long_next  = long_reg;
        word_next  = word_reg;
        ext_next   = ext_reg;
        ipc_next   = ipc_reg;
        if (en_fc) begin
            if (br_req) begin
                // Redirect: drop the slot and any half-assembled long word.
                pc_next    = br_target;
                state_next = FETCH;
                valid_next = 1'b0;
                long_next  = 1'b0;
            end else begin
                case (state_reg)
                    BOOT: begin
                        // Flash output is not trustworthy until after this edge.
                        state_next = FETCH;
                    end
                    FETCH: begin
                        if (free) begin
                            word_next = fm_data;
                            ipc_next  = pc_reg;
                            pc_next   = pc_reg + PC_ONE;
                            long_next = 1'b0;
                            ext_next  = '0;
                            if (is_long) begin
                                valid_next = 1'b0;
                                state_next = FETCH2;
                            end else begin
                                valid_next = 1'b1;
                            end
                        end
                    end
                    FETCH2: begin
                        // Slot is empty here, so the second word always lands.
                        ext_next   = fm_data;
                        long_next  = 1'b1;
                        valid_next = 1'b1;
                        pc_next    = pc_reg + PC_ONE;
                        state_next = FETCH;
                    end
                    default: begin
                        state_next = BOOT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed bench for fetch_ctrl with a flash model and a
// scoreboard of expected decoder transfers. Expectations follow the build:
// FC_LONG_INST_EN defined assembles long words, undefined gives single slots.
module tb_fetch_ctrl;

    logic        clk_fc = 1'b0;
    logic        rst_fc;
    logic        en_fc;
    logic [7:0]  fm_addr;
    logic        fm_en;
    logic [15:0] fm_data;
    logic        br_req;
    logic [7:0]  br_target;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] inst_word;
    logic [15:0] inst_ext;
    logic        inst_long;
    logic [7:0]  inst_pc;

    logic [15:0] mem [256];

    typedef struct packed {
        logic [15:0] word;
        logic [15:0] ext;
        logic        lng;
        logic [7:0]  pc;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   n_xfer = 0;

    always #5 clk_fc = ~clk_fc;

    assign fm_data = mem[fm_addr];

    fetch_ctrl #(
        .size_inst(16),
        .size_fm  (8),
        .RST_VEC  (0)
    ) dut (
        .clk_fc    (clk_fc),
        .rst_fc    (rst_fc),
        .en_fc     (en_fc),
        .fm_addr   (fm_addr),
        .fm_en     (fm_en),
        .fm_data   (fm_data),
        .br_req    (br_req),
        .br_target (br_target),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst_word (inst_word),
        .inst_ext  (inst_ext),
        .inst_long (inst_long),
        .inst_pc   (inst_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [15:0] w, input logic [15:0] e, input logic l, input logic [7:0] p);
        exp_t x;
        x.word = w;
        x.ext  = e;
        x.lng  = l;
        x.pc   = p;
        exp_q.push_back(x);
    endtask

    // One clock cycle: score a transfer if the handshake happens on the
    // coming edge, then advance to just after that edge.
    task automatic cyc();
        exp_t e;
        #2;
        if (inst_valid === 1'b1 && inst_ready && en_fc && !rst_fc) begin
            n_xfer++;
            if (exp_q.size() == 0) begin
                chk("xfer_unexpected_pc", {24'h0, inst_pc}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("xfer_word", {16'h0, inst_word}, {16'h0, e.word});
                chk("xfer_ext",  {16'h0, inst_ext},  {16'h0, e.ext});
                chk("xfer_long", {31'h0, inst_long}, {31'h0, e.lng});
                chk("xfer_pc",   {24'h0, inst_pc},   {24'h0, e.pc});
                $display("xfer pc=%02h word=%04h ext=%04h long=%0d", inst_pc, inst_word, inst_ext, inst_long);
            end
        end
        @(posedge clk_fc);
        #1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            cyc();
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout_left", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        rst_fc     = 1'b1;
        en_fc      = 1'b1;
        inst_ready = 1'b0;
        br_req     = 1'b0;
        br_target  = 8'h00;
        cyc();
        cyc();
        exp_q.delete();
        n_xfer = 0;
        rst_fc = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0100 + 16'(i);
        mem[0] = 16'h210E;
        mem[1] = 16'h0D11;
        mem[2] = 16'h210E;
        mem[3] = 16'h940C;
        mem[4] = 16'h0042;

        // ---- Reset values while reset is held ----
        rst_fc = 1'b1;
        en_fc = 1'b1;
        inst_ready = 1'b0;
        br_req = 1'b0;
        br_target = 8'h00;
        #1;
        cyc();
        chk("rst_valid", {31'h0, inst_valid}, 0);
        chk("rst_long",  {31'h0, inst_long}, 0);
        chk("rst_word",  {16'h0, inst_word}, 0);
        chk("rst_ext",   {16'h0, inst_ext}, 0);
        chk("rst_ipc",   {24'h0, inst_pc}, 0);
        chk("rst_addr",  {24'h0, fm_addr}, 0);
        chk("rst_fm_en", {31'h0, fm_en}, 1);

        // ---- Streaming with ready held high ----
        do_reset();
        inst_ready = 1'b1;
        push(16'h210E, 16'h0, 1'b0, 8'd0);
        push(16'h0D11, 16'h0, 1'b0, 8'd1);
        push(16'h210E, 16'h0, 1'b0, 8'd2);
        cyc();
        chk("boot_no_valid", {31'h0, inst_valid}, 0);
        cyc();
        chk("first_valid_2nd_edge", {31'h0, inst_valid}, 1);
        cyc();
        cyc();
        cyc();
        chk("stream_xfers", n_xfer, 3);
        chk("stream_queue_empty", exp_q.size(), 0);
        inst_ready = 1'b0;

        // ---- Stall: slot and pc hold while ready is low ----
        do_reset();
        cyc();
        cyc();
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("stall_valid", {31'h0, inst_valid}, 1);
            chk("stall_word", {16'h0, inst_word}, 32'h210E);
            chk("stall_ipc", {24'h0, inst_pc}, 0);
            chk("stall_pc", {24'h0, fm_addr}, 1);
        end
        push(16'h210E, 16'h0, 1'b0, 8'd0);
        push(16'h0D11, 16'h0, 1'b0, 8'd1);
        inst_ready = 1'b1;
        cyc();
        cyc();
        inst_ready = 1'b0;
        cyc();
        chk("resume_queue_empty", exp_q.size(), 0);
        chk("slot_pc2", {24'h0, inst_pc}, 2);

        // ---- Enable low freezes everything, ready ignored ----
        en_fc = 1'b0;
        inst_ready = 1'b1;
        cyc();
        cyc();
        chk("en_low_fm_en", {31'h0, fm_en}, 0);
        chk("en_low_valid", {31'h0, inst_valid}, 1);
        chk("en_low_ipc", {24'h0, inst_pc}, 2);
        chk("en_low_pc", {24'h0, fm_addr}, 3);
        en_fc = 1'b1;
        inst_ready = 1'b0;

        // ---- Branch drops the unconsumed slot ----
        br_req = 1'b1;
        br_target = 8'h05;
        cyc();
        br_req = 1'b0;
        chk("br_drop_valid", {31'h0, inst_valid}, 0);
        chk("br_pc", {24'h0, fm_addr}, 5);
        push(16'h0105, 16'h0, 1'b0, 8'd5);
        inst_ready = 1'b1;
        drain(6);
        inst_ready = 1'b0;

        // ---- JMP at address 3 ----
        do_reset();
        inst_ready = 1'b1;
        push(16'h210E, 16'h0, 1'b0, 8'd0);
        push(16'h0D11, 16'h0, 1'b0, 8'd1);
        push(16'h210E, 16'h0, 1'b0, 8'd2);
`ifdef FC_LONG_INST_EN
        push(16'h940C, 16'h0042, 1'b1, 8'd3);
`else
        push(16'h940C, 16'h0000, 1'b0, 8'd3);
        push(16'h0042, 16'h0000, 1'b0, 8'd4);
`endif
        push(16'h0105, 16'h0, 1'b0, 8'd5);
        drain(20);
        inst_ready = 1'b0;

        // ---- Branch during BOOT to 0xFF, long word wraps to address 0 ----
        mem[8'hFF] = 16'h940C;
        mem[0] = 16'h1234;
        do_reset();
        br_req = 1'b1;
        br_target = 8'hFF;
        cyc();
        br_req = 1'b0;
        chk("boot_br_pc", {24'h0, fm_addr}, 32'hFF);
        chk("boot_br_valid", {31'h0, inst_valid}, 0);
`ifdef FC_LONG_INST_EN
        push(16'h940C, 16'h1234, 1'b1, 8'hFF);
`else
        push(16'h940C, 16'h0000, 1'b0, 8'hFF);
        push(16'h1234, 16'h0000, 1'b0, 8'h00);
`endif
        push(16'h0D11, 16'h0, 1'b0, 8'h01);
        inst_ready = 1'b1;
        drain(20);
        inst_ready = 1'b0;
        mem[8'hFF] = 16'h01FF;
        mem[0] = 16'h210E;

        // ---- Asynchronous reset in the middle of a long fetch ----
        do_reset();
        br_req = 1'b1;
        br_target = 8'h02;
        cyc();
        br_req = 1'b0;
        push(16'h210E, 16'h0, 1'b0, 8'd2);
        inst_ready = 1'b1;
        cyc();
        cyc();
        chk("pre_rst_queue_empty", exp_q.size(), 0);
        chk("pre_rst_word", {16'h0, inst_word}, 32'h940C);
        #2;
        rst_fc = 1'b1;
        #1;
        chk("async_rst_valid", {31'h0, inst_valid}, 0);
        chk("async_rst_word", {16'h0, inst_word}, 0);
        chk("async_rst_ipc", {24'h0, inst_pc}, 0);
        chk("async_rst_pc", {24'h0, fm_addr}, 0);
        chk("async_rst_fm_en", {31'h0, fm_en}, 1);
        @(posedge clk_fc);
        #1;
        rst_fc = 1'b0;
        inst_ready = 1'b0;
        cyc();
        chk("post_rst_boot_valid", {31'h0, inst_valid}, 0);
        cyc();
        chk("post_rst_valid", {31'h0, inst_valid}, 1);
        chk("post_rst_word", {16'h0, inst_word}, 32'h210E);
        chk("post_rst_ipc", {24'h0, inst_pc}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the 16-bit-word Flash_Mem program store.
- Owns the program counter and drives the flash read address.
- Latches the returned word into an instruction slot and hands it to the decoder with a valid/ready handshake.
- Handles branch redirects and, optionally, two-word AVR instructions (LDS/STS/JMP/CALL).

Parameters:
- size_inst, 16, instruction word width
- size_fm, 8, program address width; the PC wraps modulo 2^size_fm
- RST_VEC, 0, PC value after reset

Ports:
- clk_fc  input  1  clock
- rst_fc  input  1  asynchronous reset, active-high
- en_fc  input  1  global enable; when low, all state is frozen
- fm_addr  output  size_fm  flash read address, connects to Id_adress
- fm_en  output  1  flash enable, connects to E
- fm_data  input  size_inst  flash read data (combinational, same cycle as fm_addr)
- br_req  input  1  branch/redirect request, sampled on the clock edge
- br_target  input  size_fm  redirect address
- inst_valid  output  1  instruction slot holds a valid instruction
- inst_ready  input  1  decoder accepts the slot this cycle
- inst_word  output  size_inst  first (or only) instruction word
- inst_ext  output  size_inst  second word of a long instruction; 0 otherwise
- inst_long  output  1  slot holds a two-word instruction
- inst_pc  output  size_fm  address of inst_word

Behaviour:
- Reset (async, rst_fc high) sets:
  - pc = RST_VEC, state = BOOT
  - inst_valid = 0, inst_long = 0
  - inst_word = 0, inst_ext = 0
  - inst_pc = 0
- Outputs stay at those values while reset is held. Reset mid-fetch discards everything; there is no partial state.
- fm_addr = pc at all times (combinational).
- fm_en = en_fc when not in BOOT; fm_en = 1 in BOOT so the flash loads its image.
- Slot free: free = !inst_valid || inst_ready.
- Handshake: a transfer occurs on an edge where inst_valid && inst_ready.
  - Slot contents stay stable while inst_valid && !inst_ready.
- en_fc low: no register changes. An inst_ready in that cycle is ignored; the slot is not consumed.
- States, all transitions on posedge clk_fc with en_fc = 1:
  - BOOT: exactly one cycle, no capture (flash contents are valid only after their first load edge). Goes to FETCH.
  - FETCH: if free, capture fm_data into inst_word, set inst_pc <= pc and pc <= pc+1.
    - If the word is long: inst_valid <= 0, go to FETCH2.
    - Otherwise: inst_valid <= 1, inst_long <= 0, inst_ext <= 0, stay in FETCH.
    - If not free, hold.
  - FETCH2: capture fm_data into inst_ext, inst_long <= 1, inst_valid <= 1, pc <= pc+1, go to FETCH. The slot is always free here.
- Throughput: one single-word instruction per cycle with inst_ready held high; a long instruction takes 2 cycles.
- Long-word detection, on fm_data:
  - (w & 16'hFC0F) == 16'h9000 for LDS/STS
  - (w & 16'hFE0C) == 16'h940C for JMP/CALL
- Branch: br_req has priority over everything except reset. On the edge:
  - pc <= br_target, state <= FETCH, inst_valid <= 0, inst_long <= 0
  - Any unconsumed slot contents and any in-progress FETCH2 are discarded.
  - A handshake on the same edge still counts as consumed.
  - No capture occurs on a branch edge.
  - The first instruction from br_target is valid one edge later.
- br_req while in BOOT: pc <= br_target, and BOOT still completes.
- Wrap-around: pc = 2^size_fm-1 increments to 0. A long instruction at the last address takes its second word from address 0.
- The PC has no halt/end detection; the external control path stops fetch with en_fc or a branch.

Optional Feature:
- Macro: FC_LONG_INST_EN.
- Defined: two-word detection and the FETCH2 state as above.
- Undefined:
  - Every word is treated as single-word and FETCH2 is never entered.
  - inst_long = 0 and inst_ext = 0 constantly.
  - The PC advances by 1 per captured word.

Test Plan:
- Reset, flash image {0x210E, 0x0D11, 0x210E}, inst_ready=1 → first valid at the 2nd edge after reset release; inst_word 0x210E/0x0D11/0x210E with inst_pc 0/1/2 on consecutive cycles; inst_long=0.
- inst_ready=0 for 3 cycles after the first valid → inst_word=0x210E and inst_pc=0 held; pc stays 1; resumes in order when ready returns.
- br_req=1, br_target=0x05 while the slot holds pc 2 unconsumed → slot dropped (inst_valid=0 next cycle); next valid has inst_pc=0x05.
- Image word 0x940C at addr 3 followed by 0x0042 (JMP), FC_LONG_INST_EN defined → one slot: inst_word=0x940C, inst_ext=0x0042, inst_long=1, inst_pc=3; next slot inst_pc=5. Undefined → two slots, inst_long=0.
- br_target=0xFF, long word at 0xFF, word 0x1234 at 0x00 → inst_ext=0x1234; next inst_pc=0x01 (wrap).
- Assert rst_fc asynchronously mid-FETCH2 → inst_valid=0 immediately, before the next edge; BOOT then FETCH from RST_VEC.
